carrier_wipeoff_accum: RTL and testbench
========================================

Name: carrier_wipeoff_accum

Overview:
- Carrier wipe-off and integrate-and-dump stage directly downstream of the 1-bit quadrature LO generator in the acquisition chain.
- Multiplies each incoming sign/magnitude IF sample by the LO I and Q bits and accumulates the products over a programmable number of samples.
- On each period boundary, presents a coherent I/Q sum to the acquisition search logic through a valid/ready handshake.

Parameters:
- ACC_W, 24, width of signed I/Q accumulators and outputs; must be >= 19 so that 3*65535 cannot overflow.
- LEN_W, 16, width of dump_len and the internal sample counter.

Ports:
- clk  in  1  sample-domain clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; latch dump_len and begin accumulating.
- stop  in  1  pulse; abort to IDLE and discard the partial sum.
- dump_len  in  LEN_W  samples per integration period.
- sample_valid  in  1  qualifies sample_sign, sample_mag, lo_i and lo_q.
- sample_sign  in  1  sign bit: 0 = positive, 1 = negative.
- sample_mag  in  1  magnitude bit: 0 = 1, 1 = 3.
- lo_i  in  1  in-phase LO bit: 1 = +1, 0 = -1.
- lo_q  in  1  quadrature LO bit: 1 = +1, 0 = -1.
- i_out  out  ACC_W  signed in-phase dump result.
- q_out  out  ACC_W  signed quadrature dump result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- dump_cnt  out  16  number of completed dumps, wraps.
- overrun  out  1  sticky: a result was overwritten before it was accepted.
- busy  out  1  high in RUN.

Behaviour:
- Reset (asynchronous, rst low): state = IDLE; accumulators, sample counter, i_out, q_out, out_valid, dump_cnt, overrun and busy all 0.

States:
- IDLE: samples are ignored.
  - start with dump_len != 0 → latch len_r = dump_len, clear accumulators, counter and overrun, go to RUN.
  - start with dump_len == 0 → ignored, stay in IDLE.
- RUN: busy = 1.
  - stop → IDLE; the partial sum is discarded; out_valid, i_out, q_out and dump_cnt are unchanged.
  - start while in RUN → treated as a restart: relatch dump_len, clear accumulators and counter. Overrun is not cleared.
  - If stop and start arrive in the same cycle, stop wins.

Mixing (combinational on accepted samples):
- v = (sample_mag ? 3 : 1), negated when sample_sign = 1.
- pi = lo_i ? v : -v.
- pq = lo_q ? v : -v.
- Each product is sign-extended to ACC_W.

Accumulation and dump:
- In RUN, each cycle with sample_valid = 1:
  - acc_i += pi, acc_q += pq, cnt += 1.
- When an accepted sample makes cnt == len_r (dump cycle):
  - i_out <= acc_i + pi and q_out <= acc_q + pq, registered.
  - acc_i, acc_q and cnt all reset to 0 in the same cycle. The next valid sample starts the next period with no dead cycle.
  - dump_cnt += 1, wrapping at 65535 → 0.
  - out_valid <= 1 on the following edge, so results are visible 1 cycle after the final sample is accepted.
  - Operation is continuous: RUN persists across dumps.

Handshake:
- The output transfers on a cycle where out_valid && out_ready; out_valid then clears unless a new dump lands in that same cycle.
- If a new dump occurs while out_valid = 1 and out_ready = 0: the outputs are overwritten, out_valid stays 1, and overrun <= 1.
- overrun is cleared only by reset or by start from IDLE.
- i_out and q_out are held stable while out_valid = 1 and no new dump occurs.

Other rules:
- Samples with sample_valid = 0 have no effect.
- sample_valid is ignored in IDLE.
- Arithmetic is two's complement with no saturation; the ACC_W constraint guarantees no overflow.

Optional Feature:
- Macro: SAMPLE_2BIT_EN.
- Defined: 2-bit sign/magnitude samples as described above, v ∈ {±1, ±3}.
- Undefined: 1-bit samples. sample_mag is ignored, v = ±1 from sample_sign only, and the products reduce to XNOR of the sign and LO bits, mapped to ±1.
- All other behaviour is identical.

Test Plan:
- Reset and start gating: hold rst low with random inputs → all outputs 0. Release rst, start with dump_len=0 → stays IDLE, busy=0.
- All-positive accumulation: dump_len=4, four valid samples with sign=0, mag=1, lo_i=1, lo_q=0 → one cycle after the 4th sample, out_valid=1, i_out=+12, q_out=-12, dump_cnt=1.
- Gapped valid and continuous operation: dump_len=3, sample_valid toggling 1,0,1,0,1 with v=+1, lo_i=lo_q=1 → i_out=q_out=3 after the 3rd valid sample. The next period starts at 0 and its dump gives dump_cnt=2.
- Backpressure: out_ready=0 across two dumps of different values → second values appear, out_valid stays 1, overrun=1. Then out_ready=1 for 1 cycle → out_valid=0 and overrun stays 1.
- Abort: stop after 2 of 5 samples → busy=0, no out_valid. Restart with start → the first dump reflects only the new 5 samples.
- Macro check: with SAMPLE_2BIT_EN undefined, dump_len=2, samples mag=1, sign=1, lo_i=1 → i_out = -2, not -6.

Source files
------------

// File: rtl/carrier_wipeoff_accum.sv
// Carrier wipe-off and integrate-and-dump: mixes IF samples with 1-bit I/Q LO and dumps coherent sums.
// Optional SAMPLE_2BIT_EN selects 2-bit sign/magnitude samples (+-1/+-3); otherwise samples are +-1.
module carrier_wipeoff_accum #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [LEN_W-1:0]        dump_len,
    input  logic                    sample_valid,
    input  logic                    sample_sign,
    input  logic                    sample_mag,
    input  logic                    lo_i,
    input  logic                    lo_q,
    output logic signed [ACC_W-1:0] i_out,
    output logic signed [ACC_W-1:0] q_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             dump_cnt,
    output logic                    overrun,
    output logic                    busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
    logic                    out_valid_q, out_valid_d;
    logic [15:0]             dump_cnt_q, dump_cnt_d;
    logic                    overrun_q, overrun_d;

    logic signed [ACC_W-1:0] mag_v;
    logic signed [ACC_W-1:0] pi, pq;
    logic [LEN_W-1:0]        cnt_inc;
    logic                    accept, dump;

    function automatic logic signed [ACC_W-1:0] mix(input logic neg,
                                                    input logic signed [ACC_W-1:0] m);
        return neg ? -m : m;
    endfunction

`ifdef SAMPLE_2BIT_EN
    assign mag_v = sample_mag ? ACC_W'(3) : ACC_W'(1);
`else
    logic unused_mag;
    assign unused_mag = sample_mag;
    assign mag_v      = ACC_W'(1);
`endif

    // Product is negative when the sample sign disagrees with the LO polarity (lo=1 means +1).
    assign pi = mix(~(sample_sign ^ lo_i), mag_v);
    assign pq = mix(~(sample_sign ^ lo_q), mag_v);

    assign cnt_inc = cnt_q + LEN_W'(1);
    assign accept  = (state_q == RUN) && sample_valid && !stop && !start;
    assign dump    = accept && (cnt_inc == len_q);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        dump_cnt_d  = dump_cnt_q;
        out_valid_d = dump | (out_valid_q & ~out_ready);
        overrun_d   = overrun_q | (dump & out_valid_q & ~out_ready);

        case (state_q)
            IDLE: begin
                if (start && !stop && (dump_len != '0)) begin
                    state_d   = RUN;
                    len_d     = dump_len;
                    cnt_d     = '0;
                    acc_i_d   = '0;
                    acc_q_d   = '0;
                    overrun_d = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_i_d = '0;
                    acc_q_d = '0;
                end else if (start) begin
                    len_d   = dump_len;
                    cnt_d   = '0;
                    acc_i_d = '0;
                    acc_q_d = '0;
                end else if (dump) begin
                    // The final sample folds straight into the dump so the next period has no dead cycle.
                    i_out_d    = acc_i_q + pi;
                    q_out_d    = acc_q_q + pq;
                    cnt_d      = '0;
                    acc_i_d    = '0;
                    acc_q_d    = '0;
                    dump_cnt_d = dump_cnt_q + 16'd1;
                end else if (accept) begin
                    acc_i_d = acc_i_q + pi;
                    acc_q_d = acc_q_q + pq;
                    cnt_d   = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_i_q     <= '0;
            acc_q_q     <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            out_valid_q <= 1'b0;
            dump_cnt_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            out_valid_q <= out_valid_d;
            dump_cnt_q  <= dump_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign out_valid = out_valid_q;
    assign dump_cnt  = dump_cnt_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_carrier_wipeoff_accum.sv
// Self-checking bench for carrier_wipeoff_accum: table-driven mixing vectors plus scoreboarded dump sequences.
module tb_carrier_wipeoff_accum;

    localparam int ACC_W = 24;
    localparam int LEN_W = 16;
`ifdef SAMPLE_2BIT_EN
    localparam int M3 = 3;
`else
    localparam int M3 = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, stop = 1'b0;
    logic [LEN_W-1:0] dump_len = '0;
    logic sample_valid = 1'b0, sample_sign = 1'b0, sample_mag = 1'b0, lo_i = 1'b0, lo_q = 1'b0;
    logic out_ready = 1'b0;
    logic signed [ACC_W-1:0] i_out, q_out;
    logic out_valid, overrun, busy;
    logic [15:0] dump_cnt;

    carrier_wipeoff_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .dump_len(dump_len),
        .sample_valid(sample_valid), .sample_sign(sample_sign), .sample_mag(sample_mag),
        .lo_i(lo_i), .lo_q(lo_q), .i_out(i_out), .q_out(q_out), .out_valid(out_valid),
        .out_ready(out_ready), .dump_cnt(dump_cnt), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {longint i; longint q; int dc;} exp_t;
    typedef struct {bit s; bit m; bit li; bit lq; int ei; int eq;} vec_t;

    exp_t   exp_q[$];
    vec_t   tbl[8];
    int     checks = 0;
    int     failures = 0;
    logic [15:0] last_dc = '0;

    // Reference model state
    bit     m_run = 0;
    int     m_len = 0, m_cnt = 0, m_dc = 0;
    longint m_ai = 0, m_aq = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int prod(input bit s, input bit m, input bit lo);
        int v;
        v = 1;
`ifdef SAMPLE_2BIT_EN
        if (m) v = 3;
`endif
        if (s) v = -v;
        if (!lo) v = -v;
        return v;
    endfunction

    // Advance the model on the current inputs, then clock the DUT.
    task automatic tick();
        if (m_run) begin
            if (stop) begin
                m_run = 0; m_cnt = 0; m_ai = 0; m_aq = 0;
            end else if (start) begin
                m_len = int'(dump_len); m_cnt = 0; m_ai = 0; m_aq = 0;
            end else if (sample_valid) begin
                m_ai += prod(sample_sign, sample_mag, lo_i);
                m_aq += prod(sample_sign, sample_mag, lo_q);
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_dc = (m_dc + 1) % 65536;
                    exp_q.push_back('{m_ai, m_aq, m_dc});
                    m_cnt = 0; m_ai = 0; m_aq = 0;
                end
            end
        end else if (start && !stop && dump_len != 0) begin
            m_run = 1; m_len = int'(dump_len); m_cnt = 0; m_ai = 0; m_aq = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input bit v, input bit s, input bit m, input bit li, input bit lq);
        sample_valid = v; sample_sign = s; sample_mag = m; lo_i = li; lo_q = lq;
        tick();
    endtask

    task automatic do_start(input int len);
        start = 1'b1; dump_len = LEN_W'(len); sample_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    // Scoreboard: every new dump (dump_cnt change) pops one expected record.
    always @(posedge clk) begin
        #1;
        if (rst && dump_cnt != last_dc) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_dump", longint'(dump_cnt), longint'(last_dc));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_i_out", longint'(i_out), e.i);
                chk("sb_q_out", longint'(q_out), e.q);
                chk("sb_dump_cnt", longint'(dump_cnt), longint'(e.dc));
            end
        end
        last_dc = dump_cnt;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 0, 1, 1,   1,   1};
        tbl[1] = '{0, 1, 1, 0,  M3, -M3};
        tbl[2] = '{1, 0, 1, 1,  -1,  -1};
        tbl[3] = '{1, 1, 0, 1,  M3, -M3};
        tbl[4] = '{0, 0, 0, 0,  -1,  -1};
        tbl[5] = '{1, 0, 0, 0,   1,   1};
        tbl[6] = '{0, 1, 0, 1, -M3,  M3};
        tbl[7] = '{1, 1, 1, 0, -M3,  M3};

        // Reset with random activity on inputs
        for (int k = 0; k < 4; k++) begin
            start = 1'($urandom); stop = 1'($urandom); dump_len = LEN_W'($urandom);
            sample_valid = 1'($urandom); sample_sign = 1'($urandom); sample_mag = 1'($urandom);
            lo_i = 1'($urandom); lo_q = 1'($urandom); out_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("rst_i_out", longint'(i_out), 0);
        chk("rst_q_out", longint'(q_out), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_dump_cnt", longint'(dump_cnt), 0);
        chk("rst_overrun", longint'(overrun), 0);
        chk("rst_busy", longint'(busy), 0);
        start = 0; stop = 0; dump_len = '0; sample_valid = 0; sample_sign = 0;
        sample_mag = 0; lo_i = 0; lo_q = 0; out_ready = 1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Start with zero length is ignored
        do_start(0);
        samp(1, 0, 0, 1, 1);
        chk("len0_busy", longint'(busy), 0);
        chk("len0_out_valid", longint'(out_valid), 0);

        // Mixing table: dump_len=1 makes each sample its own dump
        do_start(1);
        chk("tbl_busy", longint'(busy), 1);
        for (int k = 0; k < 8; k++) begin
            samp(1, tbl[k].s, tbl[k].m, tbl[k].li, tbl[k].lq);
            chk($sformatf("tbl%0d_i", k), longint'(i_out), longint'(tbl[k].ei));
            chk($sformatf("tbl%0d_q", k), longint'(q_out), longint'(tbl[k].eq));
            chk($sformatf("tbl%0d_valid", k), longint'(out_valid), 1);
        end
        samp(0, 0, 0, 0, 0);
        chk("tbl_drain_valid", longint'(out_valid), 0);
        stop = 1; tick(); stop = 0;

        // Four-sample accumulation, result one cycle after the last sample
        do_start(4);
        for (int k = 0; k < 3; k++) samp(1, 0, 1, 1, 0);
        chk("acc4_not_yet", longint'(out_valid), 0);
        samp(1, 0, 1, 1, 0);
        chk("acc4_valid", longint'(out_valid), 1);
        chk("acc4_i", longint'(i_out), 4 * M3);
        chk("acc4_q", longint'(q_out), -4 * M3);
        chk("acc4_cnt", longint'(dump_cnt), 9);

        // Gapped valid with restart from RUN, then a back-to-back period
        do_start(3);
        samp(1, 0, 0, 1, 1); samp(0, 1, 1, 0, 0); samp(1, 0, 0, 1, 1);
        samp(0, 1, 1, 0, 0); samp(1, 0, 0, 1, 1);
        chk("gap_i", longint'(i_out), 3);
        chk("gap_q", longint'(q_out), 3);
        chk("gap_cnt", longint'(dump_cnt), 10);
        for (int k = 0; k < 3; k++) samp(1, 1, 0, 1, 1);
        chk("cont_i", longint'(i_out), -3);
        chk("cont_cnt", longint'(dump_cnt), 11);

        // Backpressure across two dumps
        samp(0, 0, 0, 0, 0);
        out_ready = 0;
        do_start(2);
        samp(1, 0, 0, 1, 1); samp(1, 0, 0, 1, 1);
        chk("bp1_valid", longint'(out_valid), 1);
        chk("bp1_overrun", longint'(overrun), 0);
        samp(0, 1, 1, 0, 0);
        chk("bp1_hold_i", longint'(i_out), 2);
        samp(1, 1, 0, 1, 1); samp(1, 1, 0, 1, 1);
        chk("bp2_valid", longint'(out_valid), 1);
        chk("bp2_overrun", longint'(overrun), 1);
        chk("bp2_i", longint'(i_out), -2);
        chk("bp2_cnt", longint'(dump_cnt), 13);
        out_ready = 1;
        samp(0, 0, 0, 0, 0);
        chk("bp_xfer_valid", longint'(out_valid), 0);
        chk("bp_xfer_overrun", longint'(overrun), 1);

        // Restart in RUN keeps overrun; abort discards partial sum
        do_start(5);
        chk("restart_overrun", longint'(overrun), 1);
        samp(1, 0, 0, 1, 1); samp(1, 0, 0, 1, 1);
        stop = 1; tick(); stop = 0;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_valid", longint'(out_valid), 0);
        samp(1, 0, 0, 1, 1);
        chk("idle_ignores", longint'(dump_cnt), 13);
        do_start(5);
        chk("start_clr_overrun", longint'(overrun), 0);
        for (int k = 0; k < 5; k++) samp(1, 1, 0, 1, 0);
        chk("abort_new_i", longint'(i_out), -5);
        chk("abort_new_q", longint'(q_out), 5);
        chk("abort_new_cnt", longint'(dump_cnt), 14);

        // Magnitude handling depends on the sample-width build option
        stop = 1; tick(); stop = 0;
        do_start(2);
        samp(1, 1, 1, 1, 1); samp(1, 1, 1, 1, 1);
        chk("mag_i", longint'(i_out), -2 * M3);

        // Simultaneous stop and start: stop wins
        stop = 1; start = 1; dump_len = 3; sample_valid = 0;
        tick();
        stop = 0; start = 0;
        chk("stop_wins_busy", longint'(busy), 0);

        samp(0, 0, 0, 0, 0);
        chk("sb_all_consumed", longint'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
